// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - PS/2 PHY, scancode FIFO and command bus signals for ps2_kbd_ctrl
interface ps2_kbd_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ps2_rx_valid;
  logic [7:0]    ps2_rx;
  logic          ps2_error;
  logic          ps2_start_tx;
  logic [7:0]    ps2_tx;
  logic          ps2_tx_busy;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_empty;
  logic [CW-1:0] rd_count;
  logic          overflow;
  logic          overflow_clr;
  logic          cmd_valid;
  logic [7:0]    cmd_data;
  logic          cmd_ready;
  logic          cmd_done;
  logic          cmd_ack_ok;
  logic          cmd_timeout;
  logic          irq;

  modport slave (
    input  ps2_rx_valid, ps2_rx, ps2_error, ps2_tx_busy,
    input  rd_en, overflow_clr, cmd_valid, cmd_data,
    output ps2_start_tx, ps2_tx,
    output rd_data, rd_empty, rd_count, overflow,
    output cmd_ready, cmd_done, cmd_ack_ok, cmd_timeout, irq
  );

  modport master (
    output ps2_rx_valid, ps2_rx, ps2_error, ps2_tx_busy,
    output rd_en, overflow_clr, cmd_valid, cmd_data,
    input  ps2_start_tx, ps2_tx,
    input  rd_data, rd_empty, rd_count, overflow,
    input  cmd_ready, cmd_done, cmd_ack_ok, cmd_timeout, irq
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard scancode FIFO plus command/ack FSM
// Optional resend-on-0xFE retry logic is enabled by defining PS2_KBD_RESEND_EN.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 2500000,
  parameter int MAX_RETRY   = 3
) (
  input logic           clk,
  input logic           reset,
  ps2_kbd_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMAX    = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    ACK_OK  = 8'hFA;
  localparam logic [7:0]    RESEND  = 8'hFE;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_RETRY < 0 || ACK_TIMEOUT < 2)
    begin : g_bad_param
      $error("ps2_kbd_ctrl: illegal parameter set");
    end

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_TX, WAIT_ACK, DONE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    cmd_byte, cmd_byte_n;
  logic [TW-1:0] timer, timer_n;
  logic          ack_ok, ack_ok_n;
  logic          timeout_flag, timeout_n;
  logic          timeout_hit;

`ifdef PS2_KBD_RESEND_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt, retry_n;
`endif

  logic          rx_good;
  logic          push_req, push_ok, pop, full;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic [7:0]    mem [FIFO_DEPTH];

  assign rx_good = bus.ps2_rx_valid & ~bus.ps2_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_byte     <= 8'h00;
      timer        <= '0;
      ack_ok       <= 1'b0;
      timeout_flag <= 1'b0;
`ifdef PS2_KBD_RESEND_EN
      retry_cnt    <= '0;
`endif
    end else begin
      state        <= state_n;
      cmd_byte     <= cmd_byte_n;
      timer        <= timer_n;
      ack_ok       <= ack_ok_n;
      timeout_flag <= timeout_n;
`ifdef PS2_KBD_RESEND_EN
      retry_cnt    <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cmd_byte_n  = cmd_byte;
    timer_n     = timer;
    ack_ok_n    = ack_ok;
    timeout_n   = timeout_flag;
    timeout_hit = 1'b0;
`ifdef PS2_KBD_RESEND_EN
    retry_n     = retry_cnt;
`endif
    if (state == LAUNCH || state == WAIT_BUSY || state == WAIT_TX || state == WAIT_ACK) begin
      timer_n     = timer + TW'(1);
      timeout_hit = (timer == TMAX);
    end
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_byte_n = bus.cmd_data;
          timer_n    = '0;
          ack_ok_n   = 1'b0;
          timeout_n  = 1'b0;
`ifdef PS2_KBD_RESEND_EN
          retry_n    = '0;
`endif
          state_n    = LAUNCH;
        end
      end
      LAUNCH:    state_n = WAIT_BUSY;
      WAIT_BUSY: if (bus.ps2_tx_busy)  state_n = WAIT_TX;
      WAIT_TX:   if (!bus.ps2_tx_busy) state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (rx_good) begin
          state_n = DONE;
          if (bus.ps2_rx == ACK_OK) begin
            ack_ok_n = 1'b1;
          end
`ifdef PS2_KBD_RESEND_EN
          else if (bus.ps2_rx == RESEND && retry_cnt < RW'(MAX_RETRY)) begin
            retry_n = retry_cnt + RW'(1);
            timer_n = '0;
            state_n = LAUNCH;
          end
`endif
        end
      end
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    // Timeout wins over any byte landing in the same cycle.
    if (timeout_hit) begin
      state_n   = DONE;
      timeout_n = 1'b1;
      ack_ok_n  = 1'b0;
    end
  end

`ifndef PS2_KBD_RESEND_EN
  logic unused_resend;
  assign unused_resend = ^RESEND;
`endif

  assign bus.ps2_start_tx = (state == LAUNCH);
  assign bus.ps2_tx       = (state == LAUNCH) ? cmd_byte : 8'h00;
  assign bus.cmd_ready    = (state == IDLE);
  assign bus.cmd_done     = (state == DONE);
  assign bus.cmd_ack_ok   = ack_ok;
  assign bus.cmd_timeout  = timeout_flag;

  // Bytes seen while awaiting an ack belong to the command, never the FIFO.
  assign push_req = rx_good & (state != WAIT_ACK) & ~timeout_hit;
  assign full     = (count == DEPTH_C);
  assign pop      = bus.rd_en & (count != '0);
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.ps2_rx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
      else if (bus.overflow_clr)    overflow_q <= 1'b0;
    end
  end

  assign bus.rd_count = count;
  assign bus.rd_empty = (count == '0);
  assign bus.rd_data  = (count == '0) ? 8'h00 : mem[rd_ptr];
  assign bus.overflow = overflow_q;
  assign bus.irq      = (count != '0);
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Sits directly downstream of the PS/2 host PHY and consumes its byte-level receive stream (rx, rx_valid, error). It also drives that PHY's transmit handshake (start_tx, tx, tx_busy).
- Buffers received scancodes in a FIFO for CPU/bus-side reads.
- Runs the command/acknowledge protocol (send byte, await 0xFA/0xFE, timeout).

Parameters:
FIFO_DEPTH, 8, scancode FIFO entries; power of two, minimum 2.
ACK_TIMEOUT, 2500000, clk cycles from command launch to required response (50 ms at 50 MHz).
MAX_RETRY, 3, resend attempts after 0xFE (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_rx  in  8  received byte from PS/2 host
ps2_rx_valid  in  1  one-cycle strobe; ps2_rx and ps2_error valid this cycle
ps2_error  in  1  parity error on current byte
ps2_start_tx  out  1  one-cycle transmit request to PS/2 host
ps2_tx  out  8  byte to transmit; valid while ps2_start_tx=1
ps2_tx_busy  in  1  PS/2 host transmit in progress
rd_en  in  1  pop FIFO head
rd_data  out  8  FIFO head (first-word fall-through); 0 when empty
rd_empty  out  1  FIFO empty
rd_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: byte dropped because FIFO full
overflow_clr  in  1  clear overflow
cmd_valid  in  1  command byte offered
cmd_data  in  8  command byte
cmd_ready  out  1  command FSM idle
cmd_done  out  1  one-cycle strobe: command finished
cmd_ack_ok  out  1  last command acknowledged with 0xFA
cmd_timeout  out  1  last command timed out
irq  out  1  level: FIFO non-empty

Behaviour:
- Only one clock and one reset are used; reset is synchronous and active-high on clk. All state updates on posedge clk.
- Reset state: FIFO empty, rd_count=0, rd_empty=1, rd_data=0, overflow=0, ps2_start_tx=0, ps2_tx=0, cmd_ready=1, cmd_done=0, cmd_ack_ok=0, cmd_timeout=0, irq=0, FSM=IDLE, timer=0, retry count=0.
- Reset mid-command aborts the command with no cmd_done.
- Receive path:
  - On ps2_rx_valid with ps2_error=1: the byte is discarded everywhere (no push, no ack decode).
  - On ps2_rx_valid with ps2_error=0 while the FSM is not in WAIT_ACK: the byte is pushed to the FIFO.
  - A push is visible on rd_data/rd_count the next cycle.
- FIFO rules:
  - Push when full: byte dropped, overflow set the next cycle.
  - Pop (rd_en) when empty: ignored.
  - Simultaneous push and pop: both occur and rd_count is unchanged. When full, the pop frees a slot and the push is accepted with no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - If overflow_clr and an overflowing push occur in the same cycle, overflow stays set.
- Command FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_TX, WAIT_ACK, DONE.
  - IDLE: cmd_ready=1. When cmd_valid=1, capture cmd_data, clear the timer, go to LAUNCH.
  - LAUNCH: ps2_start_tx=1 for exactly one cycle with ps2_tx=captured byte; go to WAIT_BUSY.
  - WAIT_BUSY: when ps2_tx_busy=1, go to WAIT_TX.
  - WAIT_TX: when ps2_tx_busy=0, go to WAIT_ACK.
  - WAIT_ACK: on the first good ps2_rx_valid byte, consume it (never enters FIFO):
    - 0xFA: cmd_ack_ok=1, cmd_timeout=0, go to DONE.
    - 0xFE: without the feature, cmd_ack_ok=0, go to DONE. With the feature, see Optional Feature.
    - Any other byte: treated as a failed ack, cmd_ack_ok=0, go to DONE.
  - DONE: cmd_done=1 for one cycle; return to IDLE.
- Timer: counts in LAUNCH through WAIT_ACK, clearing on each (re)launch. On reaching ACK_TIMEOUT-1 in any of those states: cmd_timeout=1, cmd_ack_ok=0, go to DONE. Timeout takes priority over a byte arriving in the same cycle; that byte is then dropped, not pushed.
- cmd_ack_ok and cmd_timeout hold until the next accepted command clears both.
- cmd_valid while not IDLE is ignored (no queuing).

Optional Feature:
PS2_KBD_RESEND_EN
- Defined: in WAIT_ACK, 0xFE with retry count < MAX_RETRY increments the retry count, clears the timer, and returns to LAUNCH to resend the same byte. 0xFE at retry count = MAX_RETRY finishes with cmd_ack_ok=0. The retry count clears on acceptance in IDLE.
- Not defined: no retry logic or counter is synthesised; 0xFE finishes immediately with cmd_ack_ok=0.

Test Plan:
- Three good bytes 0x1C,0xF0,0x1C with no rd_en -> rd_count=3, irq=1, rd_data=0x1C; three pops -> 0x1C,0xF0,0x1C, then rd_empty=1, irq=0.
- Byte 0x33 with ps2_error=1 -> rd_count unchanged, overflow=0.
- FIFO_DEPTH=8: nine good bytes -> rd_count=8, overflow=1, ninth byte lost. Push and pop in the same cycle while full -> count stays 8, overflow unchanged. overflow_clr -> overflow=0.
- cmd 0xED, ps2_tx_busy high 10 cycles then low, response 0xFA -> one ps2_start_tx pulse with ps2_tx=0xED, cmd_done pulse, cmd_ack_ok=1, FIFO unchanged.
- cmd 0xFF with no response, ACK_TIMEOUT=100 -> cmd_done exactly 100 cycles after LAUNCH, cmd_timeout=1. A byte arriving on that same cycle is not pushed.
- With PS2_KBD_RESEND_EN, MAX_RETRY=3, responses 0xFE,0xFE,0xFA -> three ps2_start_tx pulses, cmd_ack_ok=1. Four 0xFE responses -> four pulses, cmd_ack_ok=0. Without the macro, one 0xFE -> one pulse, cmd_ack_ok=0.
